// File: rtl/fft_in_buffer.sv
// fft_in_buffer: ping-pong capture buffer between the CP-stripped LTE sample
// stream and the FFT core. One symbol of 2^ADDR_NBIT >> fft_num samples is
// captured per bank and replayed as a single gap-free sop/eop burst.
// Build option: define FFT_IN_BITREV_EN to read each symbol in bit-reversed
// order (DIT input to the core); otherwise samples leave in natural order.
module fft_in_buffer #(
    parameter int unsigned DATA_NBIT = 16,
    parameter int unsigned ADDR_NBIT = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           fft_num,
    input  logic                 cp_type,
    input  logic [DATA_NBIT-1:0] din_i,
    input  logic [DATA_NBIT-1:0] din_q,
    input  logic                 din_h,
    input  logic                 din_s,
    input  logic                 din_v,
    input  logic                 fft_rdy,
    output logic [DATA_NBIT-1:0] dout_i,
    output logic [DATA_NBIT-1:0] dout_q,
    output logic                 dout_v,
    output logic                 dout_sop,
    output logic                 dout_eop,
    output logic [2:0]           dout_fft_num,
    output logic                 dout_cp_type,
    output logic                 dout_slot_start,
    output logic                 err_short,
    output logic                 err_ovf,
    output logic                 err_size
);

    localparam int unsigned         WORD_NBIT   = 2 * DATA_NBIT;
    localparam int unsigned         MEM_DEPTH   = 1 << (ADDR_NBIT + 1);
    localparam logic [2:0]          MAX_FFT_NUM = 3'd4;
    localparam logic [ADDR_NBIT-1:0] ADDR_ONES  = '1;

    typedef enum logic {W_IDLE, W_CAP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} rstate_t;

    // Storage: bank index is the MSB of the RAM address
    logic [WORD_NBIT-1:0] ram_q [MEM_DEPTH];
    logic [WORD_NBIT-1:0] rdata_q;

    // Per-bank state
    logic [1:0]           full_q;
    logic [2:0]           bank_fnum_q [2];
    logic [1:0]           bank_cp_q;
    logic [1:0]           bank_slot_q;

    // Write side
    wstate_t              wstate_q;
    logic                 wbank_q;
    logic [ADDR_NBIT-1:0] wcnt_q;
    logic [ADDR_NBIT-1:0] wlast_q;

    // Read side
    rstate_t              rstate_q;
    logic                 rbank_q;
    logic [ADDR_NBIT-1:0] rcnt_q;
    logic [2:0]           rd_fnum_q;
    logic                 rd_cp_q;
    logic                 rd_slot_q;

    // Read pipeline stage aligned with the RAM output register
    logic                 s1_v_q;
    logic                 s1_sop_q;
    logic                 s1_eop_q;
    logic [2:0]           s1_fnum_q;
    logic                 s1_cp_q;
    logic                 s1_slot_q;

    logic                 hdr_c;
    logic                 size_bad_c;
    logic                 hdr_ok_c;
    logic                 wr_en_c;
    logic                 wr_done_c;
    logic [ADDR_NBIT-1:0] wr_addr_c;
    logic                 rd_start_c;
    logic                 rd_en_c;
    logic                 rd_clr_c;
    logic [ADDR_NBIT-1:0] rlast_c;
    logic [ADDR_NBIT-1:0] rd_addr_c;
`ifdef FFT_IN_BITREV_EN
    logic [ADDR_NBIT-1:0] rev_c;
`endif

    // Control decode shared by both FSMs, the full flags and the RAM ports
    always_comb begin
        hdr_c      = din_v & din_h;
        size_bad_c = (fft_num > MAX_FFT_NUM);
        hdr_ok_c   = hdr_c & ~size_bad_c & ~full_q[wbank_q];
        wr_en_c    = ~reset & (hdr_ok_c | (din_v & ~din_h & (wstate_q == W_CAP)));
        wr_addr_c  = hdr_ok_c ? '0 : wcnt_q;
        wr_done_c  = din_v & ~din_h & (wstate_q == W_CAP) & (wcnt_q == wlast_q);
        rd_start_c = (rstate_q == R_IDLE) & full_q[rbank_q] & fft_rdy;
        rd_en_c    = (rstate_q == R_RUN);
        rd_clr_c   = (rstate_q == R_DONE);
        rlast_c    = ADDR_ONES >> rd_fnum_q;
    end

    // Read address: natural count or its log2(N)-bit reversal
    always_comb begin
        rd_addr_c = rcnt_q;
`ifdef FFT_IN_BITREV_EN
        rev_c = '0;
        for (int unsigned b = 0; b < ADDR_NBIT; b++) begin
            rev_c[b] = rcnt_q[ADDR_NBIT-1-b];
        end
        // Reversal over the full width, then drop the fft_num unused low bits
        rd_addr_c = rev_c >> rd_fnum_q;
`endif
    end

    // Sample RAM: one write port, one registered read port, contents not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            ram_q[{wbank_q, wr_addr_c}] <= {din_i, din_q};
        end
        if (rd_en_c) begin
            rdata_q <= ram_q[{rbank_q, rd_addr_c}];
        end
    end

    // Write FSM: header qualification, sample capture, error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q       <= W_IDLE;
            wbank_q        <= 1'b0;
            wcnt_q         <= '0;
            wlast_q        <= '0;
            bank_fnum_q[0] <= '0;
            bank_fnum_q[1] <= '0;
            bank_cp_q      <= '0;
            bank_slot_q    <= '0;
            err_short      <= 1'b0;
            err_ovf        <= 1'b0;
            err_size       <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_ovf   <= 1'b0;
            err_size  <= 1'b0;
            if (hdr_c) begin
                // A capture in progress never reaches N here: completion leaves W_CAP
                err_short <= (wstate_q == W_CAP);
                if (size_bad_c) begin
                    err_size <= 1'b1;
                    wstate_q <= W_IDLE;
                    wcnt_q   <= '0;
                end else if (full_q[wbank_q]) begin
                    err_ovf  <= 1'b1;
                    wstate_q <= W_IDLE;
                    wcnt_q   <= '0;
                end else begin
                    wstate_q             <= W_CAP;
                    wcnt_q               <= ADDR_NBIT'(1);
                    wlast_q              <= ADDR_ONES >> fft_num;
                    bank_fnum_q[wbank_q] <= fft_num;
                    bank_cp_q[wbank_q]   <= cp_type;
                    bank_slot_q[wbank_q] <= din_s;
                end
            end else if (din_v && (wstate_q == W_CAP)) begin
                if (wr_done_c) begin
                    wstate_q <= W_IDLE;
                    wbank_q  <= ~wbank_q;
                    wcnt_q   <= '0;
                end else begin
                    wcnt_q <= wcnt_q + ADDR_NBIT'(1);
                end
            end
        end
    end

    // Bank full flags: set by the writer on completion, cleared by the reader
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
        end else begin
            if (wr_done_c) begin
                full_q[wbank_q] <= 1'b1;
            end
            if (rd_clr_c) begin
                full_q[rbank_q] <= 1'b0;
            end
        end
    end

    // Read FSM: start on full bank + fft_rdy, then stream N addresses gap-free
    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            rbank_q   <= 1'b0;
            rcnt_q    <= '0;
            rd_fnum_q <= '0;
            rd_cp_q   <= 1'b0;
            rd_slot_q <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (rd_start_c) begin
                        rstate_q  <= R_RUN;
                        rcnt_q    <= '0;
                        rd_fnum_q <= bank_fnum_q[rbank_q];
                        rd_cp_q   <= bank_cp_q[rbank_q];
                        rd_slot_q <= bank_slot_q[rbank_q];
                    end
                end
                R_RUN: begin
                    if (rcnt_q == rlast_c) begin
                        rstate_q <= R_DONE;
                        rcnt_q   <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + ADDR_NBIT'(1);
                    end
                end
                R_DONE: begin
                    rbank_q  <= ~rbank_q;
                    rstate_q <= R_IDLE;
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    // Framing and side-info travel alongside the RAM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            s1_fnum_q <= '0;
            s1_cp_q   <= 1'b0;
            s1_slot_q <= 1'b0;
        end else begin
            s1_v_q    <= rd_en_c;
            s1_sop_q  <= rd_en_c & (rcnt_q == '0);
            s1_eop_q  <= rd_en_c & (rcnt_q == rlast_c);
            s1_fnum_q <= rd_en_c ? rd_fnum_q : 3'd0;
            s1_cp_q   <= rd_en_c & rd_cp_q;
            s1_slot_q <= rd_en_c & rd_slot_q;
        end
    end

    // Registered output stage; idle outputs are driven to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_i          <= '0;
            dout_q          <= '0;
            dout_v          <= 1'b0;
            dout_sop        <= 1'b0;
            dout_eop        <= 1'b0;
            dout_fft_num    <= '0;
            dout_cp_type    <= 1'b0;
            dout_slot_start <= 1'b0;
        end else begin
            dout_i          <= s1_v_q ? rdata_q[WORD_NBIT-1:DATA_NBIT] : '0;
            dout_q          <= s1_v_q ? rdata_q[DATA_NBIT-1:0] : '0;
            dout_v          <= s1_v_q;
            dout_sop        <= s1_sop_q;
            dout_eop        <= s1_eop_q;
            dout_fft_num    <= s1_fnum_q;
            dout_cp_type    <= s1_cp_q;
            dout_slot_start <= s1_slot_q;
        end
    end

endmodule

// File: tb/tb_fft_in_buffer.sv
// tb_fft_in_buffer: scoreboard bench for fft_in_buffer. Expected samples are
// queued when a symbol is driven and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_fft_in_buffer;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 11;
`ifdef FFT_IN_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    fft_num;
    logic          cp_type;
    logic [DW-1:0] din_i, din_q;
    logic          din_h, din_s, din_v;
    logic          fft_rdy;
    logic [DW-1:0] dout_i, dout_q;
    logic          dout_v, dout_sop, dout_eop;
    logic [2:0]    dout_fft_num;
    logic          dout_cp_type, dout_slot_start;
    logic          err_short, err_ovf, err_size;

    fft_in_buffer #(.DATA_NBIT(DW), .ADDR_NBIT(AW)) dut (
        .clk(clk), .reset(reset), .fft_num(fft_num), .cp_type(cp_type),
        .din_i(din_i), .din_q(din_q), .din_h(din_h), .din_s(din_s), .din_v(din_v),
        .fft_rdy(fft_rdy), .dout_i(dout_i), .dout_q(dout_q), .dout_v(dout_v),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_fft_num(dout_fft_num),
        .dout_cp_type(dout_cp_type), .dout_slot_start(dout_slot_start),
        .err_short(err_short), .err_ovf(err_ovf), .err_size(err_size)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] exp_q [$];
    int          len_q [$];

    int bursts    = 0;
    int out_cnt   = 0;
    int blen      = 0;
    int sop_cyc   = 0;
    int last_v_cyc = 0;
    bit in_burst  = 1'b0;
    int n_short   = 0;
    int n_ovf     = 0;
    int n_size    = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] i, input logic [15:0] q,
                                         input logic sop, input logic eop,
                                         input logic [2:0] fn, input logic cp, input logic sl);
        return 64'({i, q, sop, eop, fn, cp, sl});
    endfunction

    function automatic logic [15:0] samp_i(input int seed, input int idx);
        return 16'(seed * 256 + idx);
    endfunction

    function automatic logic [15:0] samp_q(input int seed, input int idx);
        return 16'((seed * 4099 + idx * 7) ^ 32'h5A5A);
    endfunction

    // Position in the captured symbol that the k-th output sample comes from
    function automatic int rd_index(input int k, input int fn);
        int l;
        int r;
        l = int'(AW) - fn;
        r = 0;
        if (!BITREV) return k;
        for (int b = 0; b < l; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (l - 1 - b));
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and scoreboard comparison
    always @(negedge clk) begin
        n_short += int'(err_short);
        n_ovf   += int'(err_ovf);
        n_size  += int'(err_size);
        if (reset) begin
            exp_q.delete();
            len_q.delete();
            in_burst = 1'b0;
        end else if (dout_v) begin
            out_cnt++;
            if (dout_sop) begin
                bursts++;
                blen     = 0;
                sop_cyc  = cyc;
                in_burst = 1'b1;
            end
            blen++;
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 64'(dout_v), 64'(0));
            end else begin
                check_val("sample", pack(dout_i, dout_q, dout_sop, dout_eop, dout_fft_num,
                                         dout_cp_type, dout_slot_start), exp_q.pop_front());
            end
            if (dout_eop) begin
                in_burst = 1'b0;
                if (len_q.size() != 0) check_val("burst_len", 64'(blen), 64'(len_q.pop_front()));
            end
        end else if (in_burst) begin
            check_val("burst_gap", 64'(dout_v), 64'(1));
        end
    end

    // Drive one symbol header + nsamp samples; optionally queue its expected burst
    task automatic send_symbol(input int fn, input bit cp, input bit sl, input int nsamp,
                               input int seed, input bit push);
        int n;
        n = 2048 >> fn;
        if (push) begin
            for (int k = 0; k < n; k++) begin
                int idx;
                idx = rd_index(k, fn);
                exp_q.push_back(pack(samp_i(seed, idx), samp_q(seed, idx), k == 0, k == n - 1,
                                     3'(fn), cp, sl));
            end
            len_q.push_back(n);
        end
        for (int s = 0; s < nsamp; s++) begin
            din_v   = 1'b1;
            din_h   = (s == 0);
            din_s   = (s == 0) ? sl : 1'b0;
            fft_num = (s == 0) ? 3'(fn) : 3'(s % 8);
            cp_type = (s == 0) ? cp : ~cp;
            din_i   = samp_i(seed, s);
            din_q   = samp_q(seed, s);
            last_v_cyc = cyc;
            @(posedge clk);
            #1;
        end
        din_v = 1'b0;
        din_h = 1'b0;
        din_s = 1'b0;
    endtask

    task automatic wait_level(input int lvl, input int max, input string tag);
        int n;
        n = 0;
        while (exp_q.size() > lvl && n < max) begin
            @(posedge clk);
            n++;
        end
        check_val(tag, 64'(exp_q.size() > lvl), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        wait_level(0, 20000, tag);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, e0, c0, t0;
        reset = 1'b1; fft_num = '0; cp_type = 1'b0; din_i = '0; din_q = '0;
        din_h = 1'b0; din_s = 1'b0; din_v = 1'b0; fft_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_data", 64'({dout_i, dout_q}), 64'(0));
        check_val("rst_ctrl", 64'({dout_v, dout_sop, dout_eop, dout_fft_num, dout_cp_type,
                                   dout_slot_start}), 64'(0));
        check_val("rst_err", 64'({err_short, err_ovf, err_size}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // One 128-pt symbol, din_i = index, check latency to sop
        fft_rdy = 1'b1;
        send_symbol(4, 1'b0, 1'b1, 128, 0, 1'b1);
        t0 = last_v_cyc;
        wait_drain("drain_single");
        check_val("latency_single", 64'(sop_cyc - t0), 64'(4));
        check_val("bursts_single", 64'(bursts), 64'(1));

        // All sizes back to back, overlapping capture and readout
        b0 = bursts;
        for (int j = 0; j < 5; j++) begin
            if (j >= 2) wait_level(2048 >> (j - 1), 10000, "bank_free");
            send_symbol(j, j[0], (j == 0) || (j == 3), 2048 >> j, j + 1, 1'b1);
        end
        wait_drain("drain_sizes");
        check_val("bursts_sizes", 64'(bursts - b0), 64'(5));

        // Three symbols with fft_rdy low: third overflows
        fft_rdy = 1'b0;
        b0 = bursts; e0 = n_ovf;
        send_symbol(3, 1'b1, 1'b1, 256, 11, 1'b1);
        send_symbol(3, 1'b0, 1'b0, 256, 12, 1'b1);
        send_symbol(3, 1'b1, 1'b0, 256, 13, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_val("ovf_pulse", 64'(n_ovf - e0), 64'(1));
        check_val("ovf_hold", 64'(bursts - b0), 64'(0));
        fft_rdy = 1'b1;
        wait_drain("drain_ovf");
        check_val("ovf_bursts", 64'(bursts - b0), 64'(2));

        // Symbol cut short at 100 samples, then a complete one
        b0 = bursts; e0 = n_short;
        send_symbol(4, 1'b1, 1'b0, 100, 21, 1'b0);
        send_symbol(4, 1'b0, 1'b1, 128, 22, 1'b1);
        wait_drain("drain_short");
        check_val("short_pulse", 64'(n_short - e0), 64'(1));
        check_val("short_bursts", 64'(bursts - b0), 64'(1));

        // Invalid size code: pulse and ignore its samples
        b0 = bursts; e0 = n_size; c0 = n_short;
        send_symbol(6, 1'b0, 1'b0, 128, 31, 1'b0);
        send_symbol(4, 1'b1, 1'b1, 128, 32, 1'b1);
        wait_drain("drain_size");
        check_val("size_pulse", 64'(n_size - e0), 64'(1));
        check_val("size_no_short", 64'(n_short - c0), 64'(0));
        check_val("size_bursts", 64'(bursts - b0), 64'(1));

        // Reset 50 samples into a 2048-pt burst
        send_symbol(0, 1'b0, 1'b1, 2048, 41, 1'b1);
        b0 = out_cnt;
        c0 = 0;
        while (out_cnt < b0 + 50 && c0 < 5000) begin
            @(posedge clk);
            c0++;
        end
        check_val("reach_mid_burst", 64'(out_cnt >= b0 + 50), 64'(1));
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("midrst_v", 64'(dout_v), 64'(0));
        check_val("midrst_all", 64'({dout_i, dout_q, dout_sop, dout_eop, dout_fft_num,
                                     dout_cp_type, dout_slot_start, err_short, err_ovf,
                                     err_size}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        b0 = bursts;
        send_symbol(4, 1'b1, 1'b0, 128, 51, 1'b1);
        t0 = last_v_cyc;
        wait_drain("drain_after_rst");
        check_val("latency_after_rst", 64'(sop_cyc - t0), 64'(4));
        check_val("bursts_after_rst", 64'(bursts - b0), 64'(1));
        check_val("leftover_len", 64'(len_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_in_buffer.md
# fft_in_buffer

Input buffer between the LTE sample source (CP-stripped symbol bursts marked by header/start/valid strobes) and the FFT core. It captures one FFT symbol of 2048>>fft_num complex samples into a ping-pong RAM. It then streams the symbol to the FFT core as a single uninterrupted burst with sop/eop framing. Write and read sides run concurrently, so the core can consume symbol k while symbol k+1 is being captured.

## Interface

Parameters:
- DATA_NBIT, 16, I/Q sample width.
- ADDR_NBIT, 11, RAM address width; 2^ADDR_NBIT = largest FFT size (2048).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fft_num  in  3  FFT size code: 0=2048, 1=1024, 2=512, 3=256, 4=128; 5..7 invalid. Sampled on din_h.
- cp_type  in  1  CP type of the current symbol. Sampled on din_h and passed through.
- din_i, din_q  in  DATA_NBIT  input sample.
- din_h  in  1  first sample of a symbol; only meaningful together with din_v.
- din_s  in  1  first symbol of a slot; only meaningful together with din_h.
- din_v  in  1  input sample valid.
- fft_rdy  in  1  FFT core can accept a new symbol; level signal, checked only when a burst would start.
- dout_i, dout_q  out  DATA_NBIT  output sample.
- dout_v  out  1  output valid.
- dout_sop, dout_eop  out  1  first and last sample of the output burst.
- dout_fft_num  out  3  size code of the symbol being output; held for the whole burst.
- dout_cp_type  out  1  CP type of the symbol being output.
- dout_slot_start  out  1  symbol was flagged din_s; held for the whole burst.
- err_short  out  1  one-cycle pulse: symbol discarded because din_h arrived before N samples.
- err_ovf  out  1  one-cycle pulse: symbol dropped because both banks were full.
- err_size  out  1  one-cycle pulse: din_h arrived with fft_num > 4.

## Operation

- N = 2^ADDR_NBIT >> fft_num, computed once at din_h and held.
- Storage: two banks of 2^ADDR_NBIT x 2*DATA_NBIT. Each bank has a full flag and stored side-info (fft_num, cp_type, slot_start).
- Write FSM, states W_IDLE and W_CAP:
  - din_h&din_v in any state:
    - If fft_num > 4: pulse err_size and go to W_IDLE.
    - Else if the target bank is full: pulse err_ovf and go to W_IDLE; all samples until the next din_h are ignored.
    - Else: write the sample at address 0, set wcnt=1, latch side-info, go to W_CAP.
  - If din_h arrives while in W_CAP with wcnt<N, also pulse err_short. The partial symbol is abandoned and the same bank is reused.
  - din_v without din_h: in W_CAP, write at address wcnt and increment wcnt. In W_IDLE, ignore.
  - When the write of sample N-1 completes: set the bank's full flag, toggle the write bank, go to W_IDLE.
- Read FSM, states R_IDLE, R_RUN, R_DONE:
  - R_IDLE: when the read bank is full and fft_rdy=1, go to R_RUN with rcnt=0.
  - R_RUN: issue one read address per cycle, rcnt 0..N-1, with no gaps.
  - After rcnt=N-1 is issued, go to R_DONE for one cycle. In R_DONE, clear the bank's full flag, toggle the read bank, and return to R_IDLE.
- A bank is never written while full and never read while not full. A same-bank conflict is impossible by construction.
- Write bank and read bank both start at bank 0 after reset.

## Timing

- Reset values:
  - All outputs 0.
  - Both full flags clear; both banks index 0.
  - FSMs in W_IDLE and R_IDLE; counters 0.
  - RAM contents are not reset.
- RAM read latency: 1 cycle, followed by a registered output stage. dout_v follows the issued address by 2 cycles.
- Latency: the last din_v of a symbol is at cycle t. The full flag is visible at t+1. If fft_rdy=1 and the read side is idle, R_RUN starts at t+2 and dout_sop is at t+4.
- dout_v stays high for exactly N consecutive cycles. dout_sop goes with the first sample, dout_eop with the last. For N=128, sop and eop are 127 cycles apart.
- Minimum gap between bursts from alternate banks: 2 cycles (R_DONE plus R_IDLE).
- If din_h and the last sample of the other bank's read occur in the same cycle, both proceed. The full flag clear and the new capture use different banks.
- If fft_rdy drops during R_RUN, the burst is not affected.
- Reset asserted mid-burst: dout_v falls on the next cycle and all buffered symbols are discarded.

## Configuration

- FFT_IN_BITREV_EN defined:
  - The read address is the log2(N)-bit bit-reversal of rcnt. Bits above log2(N) are 0.
  - The core receives decimation-in-time ordered input.
- Not defined: the read address equals rcnt (natural order).
- Framing, latency and error behaviour are identical in both builds.

## Test plan

- Reset, then one 128-pt symbol with din_i = index, fft_rdy=1:
  - dout_sop at 4 cycles after the last din_v, followed by 128 dout_v.
  - Natural build: dout_i = 0..127.
  - Bitrev build: dout_i = 0, 64, 32, 96, ...
- Sizes cycled 2048, 1024, 512, 256, 128 back to back:
  - Each burst length equals N.
  - dout_fft_num matches; dout_cp_type and dout_slot_start track the inputs.
- fft_rdy=0 while three 256-pt symbols arrive:
  - Symbols 1 and 2 are buffered; symbol 3 gives err_ovf=1 for one cycle.
  - After fft_rdy=1, exactly two bursts come out, holding symbols 1 and 2.
- 128-pt symbol cut at 100 samples by a new din_h:
  - err_short pulses and no burst is output for the cut symbol.
  - The next complete symbol is output intact from the same bank.
- din_h with fft_num=6: err_size pulses and all samples until the next valid din_h are ignored.
- Reset asserted 50 samples into a 2048-pt output burst:
  - dout_v=0 on the next cycle; all outputs 0.
  - A new symbol after reset is output from bank 0 with normal latency.
